// File: rtl/pc_fetch_if.sv
// Fetch-unit bus bundle: branch-unit redirect, downstream handshake and instruction memory port.
interface pc_fetch_if;
  logic        pcmux;
  logic [31:0] addr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] now_addr;
  logic [31:0] icount;
  logic [1:0]  fault;

  // Fetch unit side
  modport slave (
    input  pcmux, addr, stall, imem_ack, imem_data,
    output imem_req, imem_addr, instr, instr_valid, now_addr, icount, fault
  );

  // Environment side: branch unit, downstream stage and instruction memory
  modport master (
    output pcmux, addr, stall, imem_ack, imem_data,
    input  imem_req, imem_addr, instr, instr_valid, now_addr, icount, fault
  );
endinterface

// File: rtl/pc_fetch.sv
// Program-counter fetch unit: FETCH/VALID/HALT sequencer with redirect, timeout and sticky fault.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [3:0]  TIMEOUT  = 4'd15
) (
  input  logic      clk,
  input  logic      rst,
  pc_fetch_if.slave bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned TW   = 4;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 4'd1);

  typedef enum logic [1:0] {FETCH, VALID, HALT} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] instr, now_addr, icount;
  logic [1:0]      fault;
  logic [TW-1:0]   tcnt;
  logic            xfer, consume, timeout_hit, misaligned;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state and datapath enables
  always_comb begin
    state_next  = state;
    xfer        = 1'b0;
    consume     = 1'b0;
    timeout_hit = 1'b0;
    misaligned  = 1'b0;
    pc_next     = bus.pcmux ? bus.addr : pc + XLEN'(4);
    case (state)
      FETCH: begin
        if (bus.imem_ack) begin
          xfer       = 1'b1;
          state_next = VALID;
        end else if (tcnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = HALT;
        end
      end
      VALID: begin
        if (!bus.stall) begin
          consume = 1'b1;
          if (pc_next[1:0] != 2'b00) begin
            misaligned = 1'b1;
            state_next = HALT;
          end else begin
            state_next = FETCH;
          end
        end
      end
      HALT:    state_next = HALT;
      default: state_next = HALT;
    endcase
  end

  // PC, captured instruction, consumption count, timeout counter and sticky fault
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= '0;
      now_addr <= '0;
      icount   <= '0;
      fault    <= 2'b00;
      tcnt     <= '0;
    end else begin
      if (xfer) begin
        instr    <= bus.imem_data;
        now_addr <= pc;
        tcnt     <= '0;
      end else if (state == FETCH) begin
        tcnt <= tcnt + TW'(1);
      end
      if (consume) begin
        icount <= icount + XLEN'(1);
        pc     <= pc_next;
      end
      if (fault == 2'b00) begin
        if (timeout_hit)     fault <= 2'b10;
        else if (misaligned) fault <= 2'b01;
      end
    end
  end

  // Memory request and valid decode directly from the state register
  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (state == VALID);
  assign bus.instr       = instr;
  assign bus.now_addr    = now_addr;
  assign bus.icount      = icount;
  assign bus.fault       = fault;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch; inputs driven and outputs sampled on the falling edge.
module tb_pc_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  pc_fetch_if bus ();

  pc_fetch #(.RESET_PC(32'h0000_3000), .TIMEOUT(4'd15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reset with a pending ack and consumption, which must be discarded
  task automatic do_reset();
    rst           = 1'b1;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'hDEAD_BEEF;
    bus.stall     = 1'b0;
    bus.pcmux     = 1'b0;
    bus.addr      = 32'h0000_0000;
    cyc();
    rst          = 1'b0;
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL reset_req got %b want 1", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 32'h0000_3000) begin n_err++; $display("FAIL reset_addr got %h want 00003000", bus.imem_addr); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 00000000", bus.instr); end
    n_cmp++; if (bus.icount !== 32'h0) begin n_err++; $display("FAIL reset_icount got %0d want 0", bus.icount); end
    n_cmp++; if (bus.fault !== 2'b00) begin n_err++; $display("FAIL reset_fault got %b want 00", bus.fault); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'h2408_0001;
    cyc();
    bus.imem_ack = 1'b0;
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got %b want 1", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h2408_0001) begin n_err++; $display("FAIL first_instr got %h want 24080001", bus.instr); end
    n_cmp++; if (bus.now_addr !== 32'h0000_3000) begin n_err++; $display("FAIL first_now_addr got %h want 00003000", bus.now_addr); end
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL first_req got %b want 0", bus.imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_a = 32'h0000_3000 + 32'(4 * i);
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_a) begin n_err++; $display("FAIL seq_fetch%0d got req=%b addr=%h want req=1 addr=%h", i, bus.imem_req, bus.imem_addr, exp_a); end
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'h0000_0100 + 32'(i);
      cyc();
      bus.imem_ack = 1'b0;
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.now_addr !== exp_a) begin n_err++; $display("FAIL seq_valid%0d got valid=%b now_addr=%h want valid=1 now_addr=%h", i, bus.instr_valid, bus.now_addr, exp_a); end
      n_cmp++; if (bus.instr !== 32'h0000_0100 + 32'(i)) begin n_err++; $display("FAIL seq_instr%0d got %h want %h", i, bus.instr, 32'h0000_0100 + 32'(i)); end
      cyc();
    end
    n_cmp++; if (bus.icount !== 32'd3) begin n_err++; $display("FAIL seq_icount got %0d want 3", bus.icount); end
    n_cmp++; if (bus.imem_addr !== 32'h0000_300C) begin n_err++; $display("FAIL seq_next_addr got %h want 0000300c", bus.imem_addr); end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.imem_ack = 1'b1;
      cyc();
      bus.imem_ack = 1'b0;
      cyc();
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'h1234_5678;
    cyc();
    bus.imem_ack = 1'b0;
    bus.stall    = 1'b1;
    bus.addr     = 32'h0000_3100;
    for (int i = 0; i < 3; i++) begin
      bus.pcmux    = (i % 2 == 0);
      bus.imem_ack = 1'b1;
      cyc();
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.now_addr !== 32'h0000_3008 || bus.instr !== 32'h1234_5678) begin n_err++; $display("FAIL stall_hold%0d got valid=%b now_addr=%h instr=%h want 1/00003008/12345678", i, bus.instr_valid, bus.now_addr, bus.instr); end
      n_cmp++; if (bus.icount !== 32'd2) begin n_err++; $display("FAIL stall_icount%0d got %0d want 2", i, bus.icount); end
    end
    bus.imem_ack = 1'b0;
    bus.stall    = 1'b0;
    bus.pcmux    = 1'b1;
    bus.addr     = 32'h0000_3040;
    cyc();
    bus.pcmux = 1'b0;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3040) begin n_err++; $display("FAIL redirect_addr got req=%b addr=%h want req=1 addr=00003040", bus.imem_req, bus.imem_addr); end
    n_cmp++; if (bus.icount !== 32'd3) begin n_err++; $display("FAIL redirect_icount got %0d want 3", bus.icount); end
    // Redirect inputs during FETCH must have no effect
    bus.pcmux = 1'b1;
    bus.addr  = 32'h0000_5000;
    cyc();
    bus.pcmux = 1'b0;
    n_cmp++; if (bus.imem_addr !== 32'h0000_3040 || bus.icount !== 32'd3) begin n_err++; $display("FAIL fetch_ignore got addr=%h icount=%0d want 00003040/3", bus.imem_addr, bus.icount); end
  endtask

  task automatic test_misaligned();
    do_reset();
    bus.imem_ack = 1'b1;
    cyc();
    bus.imem_ack = 1'b0;
    bus.stall    = 1'b0;
    bus.pcmux    = 1'b1;
    bus.addr     = 32'h0000_3042;
    cyc();
    bus.pcmux = 1'b0;
    n_cmp++; if (bus.fault !== 2'b01) begin n_err++; $display("FAIL misal_fault got %b want 01", bus.fault); end
    n_cmp++; if (bus.imem_addr !== 32'h0000_3042) begin n_err++; $display("FAIL misal_pc got %h want 00003042", bus.imem_addr); end
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.fault !== 2'b01) begin n_err++; $display("FAIL halt_hold%0d got req=%b valid=%b fault=%b want 0/0/01", i, bus.imem_req, bus.instr_valid, bus.fault); end
    end
    n_cmp++; if (bus.icount !== 32'd1) begin n_err++; $display("FAIL halt_icount got %0d want 1", bus.icount); end
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 14; i++) cyc();
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.fault !== 2'b00) begin n_err++; $display("FAIL tmo_before got req=%b fault=%b want 1/00", bus.imem_req, bus.fault); end
    cyc();
    n_cmp++; if (bus.imem_req !== 1'b0 || bus.fault !== 2'b10) begin n_err++; $display("FAIL tmo_hit got req=%b fault=%b want 0/10", bus.imem_req, bus.fault); end
    do_reset();
    n_cmp++; if (bus.fault !== 2'b00 || bus.imem_addr !== 32'h0000_3000 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL tmo_clear got fault=%b addr=%h req=%b want 00/00003000/1", bus.fault, bus.imem_addr, bus.imem_req); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.imem_ack = 1'b1;
    cyc();
    bus.imem_ack = 1'b0;
    bus.pcmux    = 1'b1;
    bus.addr     = 32'hFFFF_FFFC;
    cyc();
    bus.pcmux = 1'b0;
    n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_redirect got %h want fffffffc", bus.imem_addr); end
    bus.imem_ack = 1'b1;
    cyc();
    bus.imem_ack = 1'b0;
    n_cmp++; if (bus.now_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_now_addr got %h want fffffffc", bus.now_addr); end
    cyc();
    n_cmp++; if (bus.imem_addr !== 32'h0000_0000 || bus.fault !== 2'b00 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_pc got addr=%h fault=%b req=%b want 00000000/00/1", bus.imem_addr, bus.fault, bus.imem_req); end
    n_cmp++; if (bus.icount !== 32'd2) begin n_err++; $display("FAIL wrap_icount got %0d want 2", bus.icount); end
  endtask

  initial begin
    bus.pcmux     = 1'b0;
    bus.addr      = 32'h0;
    bus.stall     = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 32'h0;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_stall_redirect();
    test_misaligned();
    test_timeout();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
